// File: rtl/eeprom_burst_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// eeprom_pkg : shared modes, error codes and FSM states for the burst sequencer
// Rev 1.0
// ==========================================================================
package eeprom_pkg;

    localparam logic [1:0] MODE_WR  = 2'd0;
    localparam logic [1:0] MODE_RD  = 2'd1;
    localparam logic [1:0] MODE_VFY = 2'd2;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_VFY  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_TWR  = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // The reserved mode code behaves exactly like a plain read.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_RD : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eeprom_burst_ctrl_if.sv
`default_nettype none
// ==========================================================================
// eeprom_burst_ctrl_if : user command bus plus single-byte engine handshake
// Rev 1.0
// ==========================================================================
interface eeprom_burst_ctrl_if #(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 4
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                   cmd_start;
    logic [1:0]             cmd_mode;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [LEN_W-1:0]       cmd_len;
    logic [8*MAX_LEN-1:0]   cmd_wdata;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;
    logic [LEN_W-1:0]       err_idx;
    logic [8*MAX_LEN-1:0]   rd_buf;

    logic                   eep_wr_req;
    logic                   eep_rd_req;
    logic [ADDR_W-1:0]      eep_addr;
    logic [7:0]             eep_wdata;
    logic [7:0]             eep_rdata;
    logic                   eep_rd_vld;
    logic                   eep_ready;

    modport master (
        output cmd_start, cmd_mode, cmd_addr, cmd_len, cmd_wdata,
        input  busy, done, err, err_code, err_idx, rd_buf,
        input  eep_wr_req, eep_rd_req, eep_addr, eep_wdata,
        output eep_rdata, eep_rd_vld, eep_ready
    );

    modport slave (
        input  cmd_start, cmd_mode, cmd_addr, cmd_len, cmd_wdata,
        output busy, done, err, err_code, err_idx, rd_buf,
        output eep_wr_req, eep_rd_req, eep_addr, eep_wdata,
        input  eep_rdata, eep_rd_vld, eep_ready
    );

endinterface
`default_nettype wire

// File: rtl/eeprom_burst_ctrl_cyc_timer.sv
`default_nettype none
// ==========================================================================
// cyc_timer : loadable down-counter; expired_o once CYC cycles follow a load
// Rev 1.0
// ==========================================================================
module cyc_timer #(
    parameter int CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expired_o
);
    localparam int W = $clog2(CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CYC - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/eeprom_burst_ctrl.sv
`default_nettype none
// ==========================================================================
// eeprom_burst_ctrl : turns one command into a write/read/verify byte burst
// Rev 1.0
// ==========================================================================
module eeprom_burst_ctrl
    import eeprom_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 4,
    parameter int TWR_CYC = 250000,
    parameter int TMO_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    eeprom_burst_ctrl_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic                       vphase_q, vphase_d;
    logic [ADDR_W-1:0]          addr_q, addr_d, start_q, start_d;
    logic [LEN_W-1:0]           len_q, len_d, idx_q, idx_d;
    logic [MAX_LEN-1:0][7:0]    wdata_q, wdata_d, rbuf_q, rbuf_d;
    logic                       seen_low_q, seen_low_d;
    logic                       err_q, err_d;
    logic [1:0]                 code_q, code_d;
    logic [LEN_W-1:0]           eidx_q, eidx_d;

    logic                       w_tmo_load, w_tmo_exp, w_twr_load, w_twr_exp;
    logic                       w_wr_req, w_rd_req, w_rd_phase;
    logic [LEN_W-1:0]           w_len_clamp, w_idx_nxt;
    logic [7:0]                 w_cur_wbyte;

    cyc_timer #(.CYC(TMO_CYC)) u_tmo (
        .clk(clk), .rst(rst), .load_i(w_tmo_load), .expired_o(w_tmo_exp)
    );

    cyc_timer #(.CYC(TWR_CYC)) u_twr (
        .clk(clk), .rst(rst), .load_i(w_twr_load), .expired_o(w_twr_exp)
    );

    always_comb begin
        if (bus.cmd_len == '0) begin
            w_len_clamp = LEN_W'(1);
        end else if (bus.cmd_len > LEN_W'(MAX_LEN)) begin
            w_len_clamp = LEN_W'(MAX_LEN);
        end else begin
            w_len_clamp = bus.cmd_len;
        end
    end

    always_comb begin
        w_cur_wbyte = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LEN_W'(i)) w_cur_wbyte = wdata_q[i];
        end
    end

    assign w_rd_phase = (mode_q == MODE_RD) || vphase_q;
    assign w_idx_nxt  = idx_q + LEN_W'(1);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        vphase_d   = vphase_q;
        addr_d     = addr_q;
        start_d    = start_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        seen_low_d = seen_low_q;
        err_d      = err_q;
        code_d     = code_q;
        eidx_d     = eidx_q;
        w_tmo_load = 1'b0;
        w_twr_load = 1'b0;
        w_wr_req   = 1'b0;
        w_rd_req   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    mode_d     = norm_mode(bus.cmd_mode);
                    vphase_d   = 1'b0;
                    addr_d     = bus.cmd_addr;
                    start_d    = bus.cmd_addr;
                    len_d      = w_len_clamp;
                    idx_d      = '0;
                    wdata_d    = bus.cmd_wdata;
                    err_d      = 1'b0;
                    code_d     = ERR_NONE;
                    eidx_d     = '0;
                    w_tmo_load = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.eep_ready) begin
                    w_wr_req   = !w_rd_phase;
                    w_rd_req   = w_rd_phase;
                    w_tmo_load = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = ST_WAIT;
                end else if (w_tmo_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    eidx_d  = idx_q;
                    state_d = ST_FIN;
                end
            end
            ST_WAIT: begin
                if (!w_rd_phase) begin
                    // Ready only means "write finished" once the engine has dropped it.
                    if (!bus.eep_ready) seen_low_d = 1'b1;
                    if (bus.eep_ready && seen_low_q) begin
                        w_twr_load = 1'b1;
                        state_d    = ST_TWR;
                    end else if (w_tmo_exp) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TMO;
                        eidx_d  = idx_q;
                        state_d = ST_FIN;
                    end
                end else if (bus.eep_rd_vld) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == LEN_W'(i)) rbuf_d[i] = bus.eep_rdata;
                    end
                    if (vphase_q && !err_q && (bus.eep_rdata != w_cur_wbyte)) begin
                        err_d  = 1'b1;
                        code_d = ERR_VFY;
                        eidx_d = idx_q;
                    end
                    state_d = ST_NEXT;
                end else if (w_tmo_exp) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    eidx_d  = idx_q;
                    state_d = ST_FIN;
                end
            end
            ST_TWR: begin
                if (w_twr_exp) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                addr_d = addr_q + ADDR_W'(1);
                if (w_idx_nxt == len_q) begin
                    if (mode_q == MODE_VFY && !vphase_q) begin
                        vphase_d   = 1'b1;
                        idx_d      = '0;
                        addr_d     = start_q;
                        w_tmo_load = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    idx_d      = w_idx_nxt;
                    w_tmo_load = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WR;
            vphase_q   <= 1'b0;
            addr_q     <= '0;
            start_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            seen_low_q <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            eidx_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            vphase_q   <= vphase_d;
            addr_q     <= addr_d;
            start_q    <= start_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            seen_low_q <= seen_low_d;
            err_q      <= err_d;
            code_q     <= code_d;
            eidx_q     <= eidx_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign bus.done       = (state_q == ST_FIN);
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
    assign bus.err_idx    = eidx_q;
    assign bus.rd_buf     = rbuf_q;
    assign bus.eep_wr_req = w_wr_req;
    assign bus.eep_rd_req = w_rd_req;
    assign bus.eep_addr   = addr_q;
    assign bus.eep_wdata  = w_cur_wbyte;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_burst_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_eeprom_burst_ctrl : directed bench with a behavioural single-byte engine
// Rev 1.0
// ==========================================================================
module tb_eeprom_burst_ctrl;
    import eeprom_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int MAX_LEN  = 4;
    localparam int TWR_CYC  = 100;
    localparam int TMO_CYC  = 500;
    localparam int ENG_BUSY = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    eeprom_burst_ctrl_if #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) bus ();

    eeprom_burst_ctrl #(
        .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .TWR_CYC(TWR_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: ready drops for ENG_BUSY cycles per transaction.
    logic [7:0] pre_mem [256];
    logic [7:0] wr_mem  [256];
    bit         wr_vld  [256];
    bit         hang     = 1'b0;
    bit         corrupt0 = 1'b0;
    int         eng_cnt;
    logic       eng_is_rd;
    logic [7:0] eng_addr, eng_data;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.eep_ready  <= 1'b1;
            bus.eep_rd_vld <= 1'b0;
            bus.eep_rdata  <= 8'h00;
            eng_cnt        <= 0;
            eng_is_rd      <= 1'b0;
            eng_addr       <= 8'h00;
            eng_data       <= 8'h00;
            for (int i = 0; i < 256; i++) wr_vld[i] <= 1'b0;
        end else begin
            bus.eep_rd_vld <= 1'b0;
            if (bus.eep_wr_req || bus.eep_rd_req) begin
                bus.eep_ready <= 1'b0;
                eng_cnt       <= ENG_BUSY;
                eng_is_rd     <= bus.eep_rd_req;
                eng_addr      <= bus.eep_addr;
                eng_data      <= bus.eep_wdata;
            end else if (eng_cnt > 0 && !hang) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    bus.eep_ready <= 1'b1;
                    if (eng_is_rd) begin
                        bus.eep_rd_vld <= 1'b1;
                        bus.eep_rdata  <= wr_vld[eng_addr] ? wr_mem[eng_addr] : pre_mem[eng_addr];
                    end else begin
                        wr_mem[eng_addr] <= (corrupt0 && eng_addr == 8'h00) ? 8'h00 : eng_data;
                        wr_vld[eng_addr] <= 1'b1;
                    end
                end
            end
        end
    end

    int         n_wr = 0, n_rd = 0, n_done = 0, proto_viol = 0;
    int         req_cyc = 0, done_cyc = 0, rise_cyc = 0;
    logic       prev_rdy = 1'b1;
    logic [7:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    logic [7:0] rd_addr_log [64];

    always @(negedge clk) begin
        if (rst) begin
            if (bus.eep_wr_req || bus.eep_rd_req) begin
                if ((bus.eep_wr_req && bus.eep_rd_req) || !bus.eep_ready) proto_viol++;
                if (bus.eep_wr_req) begin
                    wr_addr_log[n_wr % 64] = bus.eep_addr;
                    wr_data_log[n_wr % 64] = bus.eep_wdata;
                    n_wr++;
                end else begin
                    rd_addr_log[n_rd % 64] = bus.eep_addr;
                    n_rd++;
                end
                req_cyc = cyc;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.eep_ready && !prev_rdy) rise_cyc = cyc;
        end
        prev_rdy = bus.eep_ready;
    end

    task automatic run_cmd(input logic [1:0] mode, input logic [7:0] addr, input logic [2:0] len,
                           input logic [31:0] wdata, input int poke, output bit tmo);
        int base;
        base = n_done;
        @(negedge clk);
        bus.cmd_mode  = mode;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_wdata = wdata;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            if (n_done != base) begin
                tmo = 1'b0;
                break;
            end
            if (poke > 0 && i == poke) begin
                bus.cmd_addr  = 8'hEE;
                bus.cmd_start = 1'b1;
                @(negedge clk);
                bus.cmd_start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.err_code, bus.err_idx, bus.rd_buf,
             bus.eep_wr_req, bus.eep_rd_req, bus.eep_addr, bus.eep_wdata} !== 58'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b err=%b rd_buf=%h addr=%h required all zero",
                     bus.busy, bus.done, bus.err, bus.rd_buf, bus.eep_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int b_wr, b_rd, b_done, dt;
        bit tmo;
        b_wr = n_wr; b_rd = n_rd; b_done = n_done;
        run_cmd(MODE_WR, 8'h03, 3'd1, 32'h0000_00C3, 0, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL write_done_timeout got no done required done"); end
        checks++;
        if (n_wr - b_wr != 1 || n_rd != b_rd) begin
            errors++; $display("FAIL write_req_count got wr=%0d rd=%0d required wr=1 rd=0", n_wr - b_wr, n_rd - b_rd);
        end
        checks++;
        if (wr_addr_log[b_wr % 64] !== 8'h03 || wr_data_log[b_wr % 64] !== 8'hC3) begin
            errors++; $display("FAIL write_addr_data got %h/%h required 03/c3", wr_addr_log[b_wr % 64], wr_data_log[b_wr % 64]);
        end
        // Completion cycle, TWR_CYC idle cycles, NEXT, then FIN.
        dt = done_cyc - rise_cyc;
        checks++;
        if (dt < TWR_CYC || dt > TWR_CYC + 4) begin
            errors++; $display("FAIL write_twr_gap got %0d required %0d..%0d", dt, TWR_CYC, TWR_CYC + 4);
        end
        checks++;
        if (bus.err !== 1'b0 || n_done - b_done != 1) begin
            errors++; $display("FAIL write_err_done got err=%b dones=%0d required err=0 dones=1", bus.err, n_done - b_done);
        end
    endtask

    task automatic test_read;
        int b_wr, b_rd;
        bit tmo;
        logic [7:0] ea;
        pre_mem[8'h10] = 8'h11; pre_mem[8'h11] = 8'h22;
        pre_mem[8'h12] = 8'h33; pre_mem[8'h13] = 8'h44;
        b_wr = n_wr; b_rd = n_rd;
        run_cmd(MODE_RD, 8'h10, 3'd4, 32'h0, 0, tmo);
        checks++;
        if (tmo || bus.rd_buf !== 32'h4433_2211) begin
            errors++; $display("FAIL read_buf got %h tmo=%b required 44332211", bus.rd_buf, tmo);
        end
        checks++;
        if (n_rd - b_rd != 4 || n_wr != b_wr || bus.err !== 1'b0) begin
            errors++; $display("FAIL read_counts got rd=%0d wr=%0d err=%b required 4 0 0", n_rd - b_rd, n_wr - b_wr, bus.err);
        end
        for (int i = 0; i < 4; i++) begin
            ea = 8'h10 + 8'(i);
            checks++;
            if (rd_addr_log[(b_rd + i) % 64] !== ea) begin
                errors++; $display("FAIL read_addr%0d got %h required %h", i, rd_addr_log[(b_rd + i) % 64], ea);
            end
        end
    endtask

    task automatic test_verify;
        int b_wr, b_rd;
        bit tmo;
        logic [7:0] ea [3];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
        corrupt0 = 1'b1;
        b_wr = n_wr; b_rd = n_rd;
        run_cmd(MODE_VFY, 8'hFE, 3'd3, 32'h000F_55AA, 0, tmo);
        corrupt0 = 1'b0;
        checks++;
        if (tmo || n_wr - b_wr != 3 || n_rd - b_rd != 3) begin
            errors++; $display("FAIL vfy_counts got wr=%0d rd=%0d tmo=%b required 3 3 0", n_wr - b_wr, n_rd - b_rd, tmo);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_addr_log[(b_wr + i) % 64] !== ea[i] || rd_addr_log[(b_rd + i) % 64] !== ea[i]) begin
                errors++; $display("FAIL vfy_addr%0d got wr=%h rd=%h required %h", i,
                                   wr_addr_log[(b_wr + i) % 64], rd_addr_log[(b_rd + i) % 64], ea[i]);
            end
        end
        // The corrupted byte lives at address 0x00, which is burst index 2.
        checks++;
        if (bus.err !== 1'b1 || bus.err_code !== ERR_VFY || bus.err_idx !== 3'd2) begin
            errors++; $display("FAIL vfy_err got err=%b code=%0d idx=%0d required 1 2 2", bus.err, bus.err_code, bus.err_idx);
        end
        checks++;
        if (bus.rd_buf !== 32'h4400_55AA) begin
            errors++; $display("FAIL vfy_buf got %h required 440055aa", bus.rd_buf);
        end
    endtask

    task automatic test_timeout;
        int b_rd, dt;
        bit tmo;
        hang = 1'b1;
        b_rd = n_rd;
        run_cmd(MODE_RD, 8'h20, 3'd2, 32'h0, 0, tmo);
        dt = done_cyc - req_cyc;
        checks++;
        if (tmo || bus.err !== 1'b1 || bus.err_code !== ERR_TMO || bus.err_idx !== 3'd0) begin
            errors++; $display("FAIL tmo_err got err=%b code=%0d idx=%0d tmo=%b required 1 1 0", bus.err, bus.err_code, bus.err_idx, tmo);
        end
        checks++;
        if (dt < TMO_CYC - 2 || dt > TMO_CYC + 2 || n_rd - b_rd != 1) begin
            errors++; $display("FAIL tmo_latency got %0d reqs=%0d required %0d+-2 reqs=1", dt, n_rd - b_rd, TMO_CYC);
        end
        // Let the abandoned read finish: its late rd_vld must not touch rd_buf.
        hang = 1'b0;
        repeat (ENG_BUSY + 10) @(negedge clk);
        checks++;
        if (bus.rd_buf !== 32'h4400_55AA || bus.busy !== 1'b0) begin
            errors++; $display("FAIL tmo_stray_vld got buf=%h busy=%b required 440055aa 0", bus.rd_buf, bus.busy);
        end
    endtask

    task automatic test_len_clamp;
        int b_rd, b_done;
        bit tmo;
        pre_mem[8'h40] = 8'h5A;
        b_rd = n_rd;
        run_cmd(MODE_RD, 8'h40, 3'd0, 32'h0, 0, tmo);
        checks++;
        if (tmo || n_rd - b_rd != 1 || bus.rd_buf !== 32'h4400_555A) begin
            errors++; $display("FAIL len0 got reqs=%0d buf=%h required 1 4400555a", n_rd - b_rd, bus.rd_buf);
        end
        pre_mem[8'h50] = 8'hA0; pre_mem[8'h51] = 8'hB1;
        pre_mem[8'h52] = 8'hC2; pre_mem[8'h53] = 8'hD3;
        b_rd = n_rd; b_done = n_done;
        run_cmd(MODE_RD, 8'h50, 3'd7, 32'h0, 5, tmo);
        repeat (40) @(negedge clk);
        checks++;
        if (tmo || n_rd - b_rd != 4 || n_done - b_done != 1) begin
            errors++; $display("FAIL len7_busy_start got reqs=%0d dones=%0d required 4 1", n_rd - b_rd, n_done - b_done);
        end
        checks++;
        if (bus.rd_buf !== 32'hD3C2_B1A0 || rd_addr_log[(b_rd + 3) % 64] !== 8'h53) begin
            errors++; $display("FAIL len7_data got buf=%h last=%h required d3c2b1a0 53", bus.rd_buf, rd_addr_log[(b_rd + 3) % 64]);
        end
        checks++;
        if (proto_viol != 0) begin
            errors++; $display("FAIL req_protocol got %0d violations required 0", proto_viol);
        end
    endtask

    task automatic test_reset_mid;
        int b_wr, b_rd;
        bit tmo;
        b_wr = n_wr;
        @(negedge clk);
        bus.cmd_mode  = MODE_WR;
        bus.cmd_addr  = 8'h30;
        bus.cmd_len   = 3'd4;
        bus.cmd_wdata = 32'h0403_0201;
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        for (int i = 0; i < 100 && n_wr == b_wr; i++) @(negedge clk);
        checks++;
        if (n_wr == b_wr) begin errors++; $display("FAIL midrst_no_req got 0 writes required 1"); end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.err_code, bus.err_idx, bus.rd_buf,
             bus.eep_wr_req, bus.eep_rd_req, bus.eep_addr, bus.eep_wdata} !== 58'd0) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b rd_buf=%h addr=%h wdata=%h required all zero",
                     bus.busy, bus.rd_buf, bus.eep_addr, bus.eep_wdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pre_mem[8'h60] = 8'h12; pre_mem[8'h61] = 8'h34;
        b_rd = n_rd;
        run_cmd(MODE_RD, 8'h60, 3'd2, 32'h0, 0, tmo);
        checks++;
        if (tmo || n_rd - b_rd != 2 || bus.err !== 1'b0 || bus.rd_buf !== 32'h0000_3412) begin
            errors++; $display("FAIL midrst_read got reqs=%0d err=%b buf=%h tmo=%b required 2 0 00003412 0",
                               n_rd - b_rd, bus.err, bus.rd_buf, tmo);
        end
    endtask

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_mode  = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_wdata = '0;
        for (int i = 0; i < 256; i++) pre_mem[i] = 8'hFF;
        test_reset();
        test_write();
        test_read();
        test_verify();
        test_timeout();
        test_len_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
